el2_exu_ffmul_seq: RTL and testbench

- Sequencer for the finite-field multiplier (ffmul) in the EXU custom-instruction path.
- Arms the multiplier once both operand registers are fully loaded, then holds its enable for the duration of the run.
- Captures the multiplier result and serves it back to the pipeline as 32-bit words.
- Reports busy, done and error status for custom-instruction stall and decode logic.

---
 rtl/el2_pkg.sv | 20 ++
 rtl/el2_ffmul_rdmux.sv | 69 ++++++
 rtl/el2_exu_ffmul_seq.sv | 168 ++++++++++++++++
 tb/tb_el2_exu_ffmul_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// ---------------------------------------------------------------------------
// el2_pkg
// Shared types and constants for the EXU finite-field multiplier sequencer.
//   el2_ffmul_state_t : sequencer FSM states
//   FFMUL_WIDTH       : ffmul operand/result width in bits
//   FFMUL_NWORDS      : number of 32-bit result words readable by the core
// ---------------------------------------------------------------------------
package el2_pkg;

    localparam int FFMUL_WIDTH  = 409;
    localparam int FFMUL_NWORDS = 13;

    typedef enum logic [1:0] {
        FFS_IDLE,
        FFS_RUN,
        FFS_CAPTURE,
        FFS_DONE
    } el2_ffmul_state_t;

endpackage

// File: rtl/el2_ffmul_rdmux.sv
// ---------------------------------------------------------------------------
// el2_ffmul_rdmux
// Registered 32-bit word select from the WIDTH-bit ffmul result buffer.
//   clk, rst     : clock, synchronous active-high reset
//   result_buf   : captured ffmul result (WIDTH bits)
//   result_ok    : buffer holds a valid result; otherwise reads return 0
//   rd_req_i     : read request; rd_valid_o follows one cycle later
//   rd_idx_i     : 32-bit word index; indices >= NWORDS read as 0
//   rd_data_o    : read data, held between requests
//   rd_valid_o   : read data valid
// The top word is zero-extended when WIDTH is not a multiple of 32.
// ---------------------------------------------------------------------------
module el2_ffmul_rdmux
    import el2_pkg::*;
#(
    parameter int WIDTH = FFMUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result_buf,
    input  logic             result_ok,
    input  logic             rd_req_i,
    input  logic [3:0]       rd_idx_i,
    output logic [31:0]      rd_data_o,
    output logic             rd_valid_o
);

    localparam int NWORDS = (WIDTH + 31) / 32;
    localparam int NSEL   = 16;   // every value of the 4-bit index

    logic [NWORDS*32-1:0] padded;
    logic [31:0]          words [NSEL];
    logic [31:0]          rd_data_reg;
    logic                 rd_valid_reg;

    // Zero-pad the buffer up to a whole number of words.
    always_comb begin
        padded             = '0;
        padded[WIDTH-1:0]  = result_buf;
    end

    // Indices past the last word decode to a constant zero word.
    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_word
            if (gi < NWORDS) begin : g_in
                assign words[gi] = padded[gi*32 +: 32];
            end else begin : g_out
                assign words[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_req_i;
            if (rd_req_i) begin
                rd_data_reg <= result_ok ? words[rd_idx_i] : 32'd0;
            end
        end
    end

    assign rd_data_o  = rd_data_reg;
    assign rd_valid_o = rd_valid_reg;

endmodule

// File: rtl/el2_exu_ffmul_seq.sv
// ---------------------------------------------------------------------------
// el2_exu_ffmul_seq
// Sequencer for the finite-field multiplier in the EXU custom-instruction
// path. Arms ffmul once both operands are loaded, holds its enable through
// the run, captures the result and serves it back as 32-bit words.
//   clk, rst              : clock, synchronous active-high reset
//   load_a/b_start_i      : first operand beat written (invalidates operand)
//   load_a/b_end_i        : last operand beat written (operand valid)
//   mul_enable_o          : ffmul enable level, high in RUN
//   mul_finish_i          : ffmul completion pulse
//   mul_result_i          : ffmul result, valid with mul_finish_i
//   rd_req_i / rd_idx_i   : result word read request / index
//   rd_data_o / rd_valid_o: read data, valid one cycle after the request
//   busy_o / done_o / err_o : run status, result valid, sticky timeout
// Build option: define EL2_FFMUL_TIMEOUT_EN to enable the RUN cycle counter
// and timeout error; without it err_o is 0 and RUN waits indefinitely.
// ---------------------------------------------------------------------------
module el2_exu_ffmul_seq
    import el2_pkg::*;
#(
    parameter int WIDTH   = FFMUL_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_a_start_i,
    input  logic             load_a_end_i,
    input  logic             load_b_start_i,
    input  logic             load_b_end_i,
    output logic             mul_enable_o,
    input  logic             mul_finish_i,
    input  logic [WIDTH-1:0] mul_result_i,
    input  logic             rd_req_i,
    input  logic [3:0]       rd_idx_i,
    output logic [31:0]      rd_data_o,
    output logic             rd_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("el2_exu_ffmul_seq: TIMEOUT out of range 16..65535");
    end

    el2_ffmul_state_t state_reg, state_next;
    logic             a_vld_reg, a_vld_next;
    logic             b_vld_reg, b_vld_next;
    logic [WIDTH-1:0] result_reg;
    logic             buf_load;
    logic             abort;
    logic             arm;

    assign abort = load_a_start_i | load_b_start_i;
    // A start pulse in the arming cycle means an operand is being rewritten,
    // so the run is held off until it is complete again.
    assign arm   = (state_reg == FFS_IDLE) & a_vld_reg & b_vld_reg & ~abort;

`ifdef EL2_FFMUL_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] CNT_SAT  = 16'(TIMEOUT);
    logic [15:0] cnt_reg, cnt_next;
    logic        err_reg, err_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FFS_IDLE;
            a_vld_reg  <= 1'b0;
            b_vld_reg  <= 1'b0;
            result_reg <= '0;
`ifdef EL2_FFMUL_TIMEOUT_EN
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            a_vld_reg  <= a_vld_next;
            b_vld_reg  <= b_vld_next;
            if (buf_load) begin
                result_reg <= mul_result_i;
            end
`ifdef EL2_FFMUL_TIMEOUT_EN
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        buf_load   = 1'b0;
`ifdef EL2_FFMUL_TIMEOUT_EN
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`endif

        // Start clears, end sets; a started run consumes both flags so the
        // next run needs a fresh pair of end pulses.
        a_vld_next = load_a_start_i ? 1'b0 : load_a_end_i ? 1'b1 : arm ? 1'b0 : a_vld_reg;
        b_vld_next = load_b_start_i ? 1'b0 : load_b_end_i ? 1'b1 : arm ? 1'b0 : b_vld_reg;

        case (state_reg)
            FFS_IDLE: begin
                if (arm) begin
                    state_next = FFS_RUN;
`ifdef EL2_FFMUL_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end
            end
            FFS_RUN: begin
`ifdef EL2_FFMUL_TIMEOUT_EN
                cnt_next = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 16'd1;
`endif
                if (abort) begin
                    state_next = FFS_IDLE;
                end else if (mul_finish_i) begin
                    state_next = FFS_CAPTURE;
                    buf_load   = 1'b1;
`ifdef EL2_FFMUL_TIMEOUT_EN
                    err_next   = 1'b0;
`endif
                end
`ifdef EL2_FFMUL_TIMEOUT_EN
                else if (cnt_reg == CNT_LAST) begin
                    state_next = FFS_IDLE;
                    err_next   = 1'b1;
                end
`endif
            end
            FFS_CAPTURE: begin
                state_next = FFS_DONE;
            end
            FFS_DONE: begin
                if (abort) begin
                    state_next = FFS_IDLE;
                end
            end
            default: begin
                state_next = FFS_IDLE;
            end
        endcase
    end

    assign mul_enable_o = (state_reg == FFS_RUN);
    assign busy_o       = (state_reg == FFS_RUN) | (state_reg == FFS_CAPTURE);
    assign done_o       = (state_reg == FFS_DONE);
`ifdef EL2_FFMUL_TIMEOUT_EN
    assign err_o        = err_reg;
`else
    assign err_o        = 1'b0;
`endif

    el2_ffmul_rdmux #(
        .WIDTH (WIDTH)
    ) u_rdmux (
        .clk        (clk),
        .rst        (rst),
        .result_buf (result_reg),
        .result_ok  (done_o),
        .rd_req_i   (rd_req_i),
        .rd_idx_i   (rd_idx_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o)
    );

endmodule

// File: tb/tb_el2_exu_ffmul_seq.sv
// ---------------------------------------------------------------------------
// tb_el2_exu_ffmul_seq
// Directed bench for the ffmul sequencer: normal run and latency, aborts,
// abort/finish collision, top-word and out-of-range reads, timeout (when
// EL2_FFMUL_TIMEOUT_EN is defined) and reset during RUN.
// ---------------------------------------------------------------------------
module tb_el2_exu_ffmul_seq;

    localparam int W   = 409;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_a_start = 1'b0;
    logic          load_a_end   = 1'b0;
    logic          load_b_start = 1'b0;
    logic          load_b_end   = 1'b0;
    logic          mul_enable;
    logic          mul_finish   = 1'b0;
    logic [W-1:0]  mul_result   = '1;
    logic          rd_req       = 1'b0;
    logic [3:0]    rd_idx       = 4'd0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    el2_exu_ffmul_seq #(
        .WIDTH   (W),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_a_start_i (load_a_start),
        .load_a_end_i   (load_a_end),
        .load_b_start_i (load_b_start),
        .load_b_end_i   (load_b_end),
        .mul_enable_o   (mul_enable),
        .mul_finish_i   (mul_finish),
        .mul_result_i   (mul_result),
        .rd_req_i       (rd_req),
        .rd_idx_i       (rd_idx),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both end pulses together; returns in the first RUN cycle.
    task automatic arm();
        load_a_end = 1'b1;
        load_b_end = 1'b1;
        step();
        load_a_end = 1'b0;
        load_b_end = 1'b0;
        step();
    endtask

    task automatic pulse_a_start();
        load_a_start = 1'b1;
        step();
        load_a_start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input string tag);
        rd_req = 1'b1;
        rd_idx = idx;
        step();
        rd_req = 1'b0;
        $display("read %s idx=%0d data=%h valid=%0b", tag, idx, rd_data, rd_valid);
        chk({tag, " valid"}, {31'd0, rd_valid}, 32'd1);
        chk({tag, " data"}, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_n;
        int done_k;
        int run_n;

        // ---------------- reset ----------------
        repeat (3) step();
        chk("rst enable", {31'd0, mul_enable}, 32'd0);
        chk("rst rd_data", rd_data, 32'd0);
        chk("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        step();

        // ---------------- normal run, N = 20 ----------------
        load_a_end = 1'b1;
        step();
        load_a_end = 1'b0;
        step();
        chk("a only no arm", {31'd0, mul_enable}, 32'd0);
        load_b_end = 1'b1;
        step();
        load_b_end = 1'b0;
        chk("arm one cycle later", {31'd0, mul_enable}, 32'd0);
        step();
        en_n   = 0;
        done_k = 0;
        for (int k = 1; k <= 30; k++) begin
            if (mul_enable) en_n++;
            if (done && done_k == 0) done_k = k;
            if (k == 21) chk("capture busy", {31'd0, busy}, 32'd1);
            if (k == 20) begin
                mul_finish = 1'b1;
                mul_result = W'(36'h1_DEADBEEF);
            end
            step();
            mul_finish = 1'b0;
            mul_result = '1;
        end
        $display("run1 enable_cycles=%0d done_cycle=%0d", en_n, done_k);
        chk("enable cycles", en_n, 32'd20);
        chk("done latency", done_k, 32'd22);
        chk("run1 done", {31'd0, done}, 32'd1);
        chk("run1 err", {31'd0, err}, 32'd0);
        rd(4'd2, 32'd0, "run1 w2");
        rd(4'd1, 32'h0000_0001, "run1 w1");
        rd(4'd0, 32'hDEAD_BEEF, "run1 w0");
        step();
        chk("rd hold data", rd_data, 32'hDEAD_BEEF);
        chk("rd valid drops", {31'd0, rd_valid}, 32'd0);

        // ---------------- clear from DONE, then abort in RUN ----------------
        pulse_a_start();
        chk("done cleared", {31'd0, done}, 32'd0);
        rd(4'd0, 32'd0, "after clear");
        arm();
        repeat (4) step();
        chk("run cycle5 enable", {31'd0, mul_enable}, 32'd1);
        load_b_start = 1'b1;
        step();
        load_b_start = 1'b0;
        chk("abort enable", {31'd0, mul_enable}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        mul_finish = 1'b1;
        mul_result = W'(36'h1_DEADBEEF);
        step();
        mul_finish = 1'b0;
        mul_result = '1;
        step();
        chk("late finish done", {31'd0, done}, 32'd0);
        chk("late finish busy", {31'd0, busy}, 32'd0);
        rd(4'd0, 32'd0, "after abort");

        // ---------------- abort and finish together ----------------
        arm();
        repeat (2) step();
        mul_finish   = 1'b1;
        mul_result   = W'(32'hCAFE_0001);
        load_a_start = 1'b1;
        step();
        mul_finish   = 1'b0;
        load_a_start = 1'b0;
        mul_result   = '1;
        chk("collision busy", {31'd0, busy}, 32'd0);
        step();
        chk("collision done", {31'd0, done}, 32'd0);

        // ---------------- all-ones result, top and out-of-range words ----------------
        arm();
        mul_finish = 1'b1;
        mul_result = '1;
        step();
        mul_finish = 1'b0;
        chk("ones capture busy", {31'd0, busy}, 32'd1);
        chk("ones capture enable", {31'd0, mul_enable}, 32'd0);
        step();
        chk("ones done", {31'd0, done}, 32'd1);
        rd(4'd12, 32'h01FF_FFFF, "ones w12");
        rd(4'd13, 32'd0, "ones w13");
        rd(4'd15, 32'd0, "ones w15");
        rd(4'd5, 32'hFFFF_FFFF, "ones w5");
        pulse_a_start();

        // ---------------- timeout / indefinite wait ----------------
        arm();
`ifdef EL2_FFMUL_TIMEOUT_EN
        run_n = 0;
        for (int k = 1; k <= 30; k++) begin
            if (mul_enable) run_n++;
            step();
        end
        $display("timeout run_cycles=%0d err=%0b", run_n, err);
        chk("timeout run cycles", run_n, TMO);
        chk("timeout err", {31'd0, err}, 32'd1);
        chk("timeout busy", {31'd0, busy}, 32'd0);
        chk("timeout done", {31'd0, done}, 32'd0);
        arm();
        chk("err sticky in run", {31'd0, err}, 32'd1);
        repeat (2) step();
        mul_finish = 1'b1;
        mul_result = W'(32'h1234_5678);
        step();
        mul_finish = 1'b0;
        mul_result = '1;
        chk("err cleared by capture", {31'd0, err}, 32'd0);
        step();
        chk("rerun done", {31'd0, done}, 32'd1);
        rd(4'd0, 32'h1234_5678, "rerun w0");
`else
        run_n = 0;
        repeat (40) step();
        $display("no-timeout wait enable=%0b err=%0b", mul_enable, err);
        chk("wait enable held", {31'd0, mul_enable}, 32'd1);
        chk("wait err zero", {31'd0, err}, 32'd0);
        load_b_start = 1'b1;
        step();
        load_b_start = 1'b0;
        chk("wait abort enable", {31'd0, mul_enable}, 32'd0);
`endif

        // ---------------- reset during RUN ----------------
        pulse_a_start();
        arm();
        step();
        load_a_end = 1'b1;
        load_b_end = 1'b1;
        step();
        load_a_end = 1'b0;
        load_b_end = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst run enable", {31'd0, mul_enable}, 32'd0);
        chk("rst run busy", {31'd0, busy}, 32'd0);
        chk("rst run err", {31'd0, err}, 32'd0);
        repeat (3) step();
        chk("flags cleared by rst", {31'd0, mul_enable}, 32'd0);
        load_a_end = 1'b1;
        step();
        load_a_end = 1'b0;
        repeat (2) step();
        chk("rearm needs b", {31'd0, mul_enable}, 32'd0);
        load_b_end = 1'b1;
        step();
        load_b_end = 1'b0;
        step();
        chk("rearm after rst", {31'd0, mul_enable}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
